// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared types and constants for the multiplier / accumulator path
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Accumulator controller states
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width of the 2x2 unsigned product (max 3*3 = 9)
    localparam int PROD_W = 4;

    // Accumulator width needed to hold n maximal products without wrapping
    function automatic int acc_width(input int n);
        return $clog2(9 * n + 1);
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_accumulator_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : multiplier
//  Brief    : Combinational 2x2 unsigned multiplier (shift-and-add of two
//             partial products)
//  Revision : 1.0  initial release
// ============================================================================
module multiplier
    import mult_pkg::*;
(
    input  logic [1:0]        A,
    input  logic [1:0]        B,
    output logic [PROD_W-1:0] O
);

    logic [1:0] pp0;
    logic [1:0] pp1;

    // Partial products: A gated by each bit of B, second one weighted by 2
    always_comb begin
        pp0 = A & {2{B[0]}};
        pp1 = A & {2{B[1]}};
        O   = {2'b00, pp0} + {1'b0, pp1, 1'b0};
    end

endmodule : multiplier
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_accumulator
//  Brief    : Accepts 2-bit operand pairs, sums N consecutive products into one
//             batch result and offers it on an output valid/ready handshake.
//             Sticky overflow flags any wrap of the ACC_W-bit accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

    localparam int CNT_W = $clog2(N);
    // Adder is wide enough for both operands plus one carry bit, so an
    // accumulator narrower than the product still detects wrap correctly.
    localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Out-of-range batch size is rejected while elaborating
    if (N < 2 || N > 15) begin : g_n_range_check
        $error("mult_accumulator: N must be in 2..15");
    end

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [PROD_W-1:0]  prod;
    logic [SUM_W-1:0]   add_full;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    multiplier u_multiplier (
        .A (a),
        .B (b),
        .O (prod)
    );

    // Running sum plus current product; any bit above ACC_W-1 is a wrap
    always_comb begin
        add_full  = SUM_W'(acc_q) + SUM_W'(prod);
        add_sum   = add_full[ACC_W-1:0];
        add_carry = |add_full[SUM_W-1:ACC_W];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, pair counter, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Next state and datapath update; clr overrides everything, dropping any
    // pair offered in the same cycle and discarding a held result
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_carry;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // Handshake outputs decoded from state; sum shows the running accumulator
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        sum       = acc_q;
        overflow  = ovf_q;
    end

endmodule : mult_accumulator
`default_nettype wire
